// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// DMEM_BYTE_EN (optional) enables byte accesses in dmem_responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int CNT_W = 4;

  // Byte writes touch one lane; word writes touch all four.
  function automatic logic [3:0] byte_lane_we(input logic [1:0] off, input logic is_byte);
    logic [3:0] lanes;
    lanes = is_byte ? (4'b0001 << off) : 4'b1111;
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage with per-lane write enables and a registered read port.
// Contents are never reset.
module dmem_array #(
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one request at a time, WAIT_CYCLES wait states, one-cycle response.
// Define DMEM_BYTE_EN to add the req_byte port and byte-lane loads/stores.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN
  input  logic        req_byte,
`endif
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  dmem_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q, valid_q, err_q, rd_ok_q;
  logic             we_q;
  logic [31:0]      addr_q, wdata_q;

  logic             accept, commit, sel_idle;
  logic             cur_we, cur_byte, acc_err;
  logic [31:0]      cur_addr, cur_wdata;
  logic [3:0]       arr_we;
  logic [31:0]      arr_wdata, arr_rdata;

  assign accept   = req_valid && ready_q;
  assign sel_idle = (state_q == IDLE);

  // With zero wait states the access commits on the accept edge, straight from the inputs.
  assign cur_we    = sel_idle ? req_we    : we_q;
  assign cur_addr  = sel_idle ? req_addr  : addr_q;
  assign cur_wdata = sel_idle ? req_wdata : wdata_q;

  assign commit  = reset && (((state_q == WAIT) && (cnt_q == '0)) ||
                             ((WAIT_CYCLES == 0) && accept));
  assign acc_err = (|cur_addr[31:ADDR_W+2]) || (!cur_byte && (|cur_addr[1:0]));

`ifdef DMEM_BYTE_EN
  logic       byte_q, rbyte_q;
  logic [1:0] lane_q;

  assign cur_byte  = sel_idle ? req_byte : byte_q;
  assign arr_wdata = cur_byte ? {4{cur_wdata[7:0]}} : cur_wdata;
  assign arr_we    = (commit && cur_we && !acc_err) ? byte_lane_we(cur_addr[1:0], cur_byte) : 4'b0000;
  assign rsp_rdata = !rd_ok_q ? 32'd0 :
                     rbyte_q  ? {24'd0, arr_rdata[{lane_q, 3'b000} +: 8]} : arr_rdata;

  always_ff @(posedge clk) begin
    if (accept) byte_q <= req_byte;
    if (commit) begin
      rbyte_q <= cur_byte;
      lane_q  <= cur_addr[1:0];
    end
  end
`else
  assign cur_byte  = 1'b0;
  assign arr_wdata = cur_wdata;
  assign arr_we    = (commit && cur_we && !acc_err) ? 4'b1111 : 4'b0000;
  assign rsp_rdata = rd_ok_q ? arr_rdata : 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
      if (commit) begin
        state_q <= RESP;
        ready_q <= 1'b0;
        valid_q <= 1'b1;
        err_q   <= acc_err;
        rd_ok_q <= !cur_we && !acc_err;
      end else begin
        case (state_q)
          IDLE: begin
            ready_q <= 1'b1;
            if (accept) begin
              state_q <= WAIT;
              ready_q <= 1'b0;
              cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
          WAIT:    cnt_q <= cnt_q - 1'b1;
          RESP: begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .addr_i  (cur_addr[ADDR_W+1:2]),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES 2, 4 and 0.
// Byte-access scenario is built only when DMEM_BYTE_EN is defined.
module tb_dmem_responder;

  logic        clk;
  logic [2:0]  rst, rv, we;
  logic [31:0] ad [3];
  logic [31:0] wd [3];
  wire  [2:0]  rdy, vld, err;
  wire  [31:0] rd [3];
`ifdef DMEM_BYTE_EN
  logic [2:0]  rb;
`endif

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .ADDR_W      (6),
      .WAIT_CYCLES ((g == 0) ? 2 : ((g == 1) ? 4 : 0))
    ) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .req_valid (rv[g]),
      .req_ready (rdy[g]),
      .req_we    (we[g]),
      .req_addr  (ad[g]),
      .req_wdata (wd[g]),
`ifdef DMEM_BYTE_EN
      .req_byte  (rb[g]),
`endif
      .rsp_valid (vld[g]),
      .rsp_rdata (rd[g]),
      .rsp_err   (err[g])
    );
  end

  // Issue one request on instance d; lat counts negedges from the accept edge to rsp_valid (0 = timeout).
  task automatic do_req(input int d, input logic w, input logic bt, input logic [31:0] a,
                        input logic [31:0] data, output logic [31:0] rdata, output logic rerr,
                        output int lat);
    int n;
    lat = 0; rdata = '0; rerr = 1'b0;
    @(negedge clk);
    rv[d] = 1'b1; we[d] = w; ad[d] = a; wd[d] = data;
`ifdef DMEM_BYTE_EN
    rb[d] = bt;
`else
    if (bt) $display("byte request issued without DMEM_BYTE_EN");
`endif
    n = 0;
    while (!rdy[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) begin
      tests++; fails++;
      $display("FAIL ready_timeout dut%0d req_ready stayed 0, required 1", d);
      rv[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rv[d] = 1'b0; we[d] = ~w; ad[d] = 32'hFFFF_FFFF; wd[d] = 32'h0BAD_0BAD;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (vld[d]) begin
        lat = k; rdata = rd[d]; rerr = err[d];
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 3'b000; rv = 3'b111; we = 3'b111;
    for (int d = 0; d < 3; d++) begin
      ad[d] = 32'h10; wd[d] = 32'h1234_5678;
    end
`ifdef DMEM_BYTE_EN
    rb = 3'b000;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        tests++;
        if ({rdy[d], vld[d], err[d]} !== 3'b000 || rd[d] !== 32'd0) begin
          fails++;
          $display("FAIL reset_outputs dut%0d cyc%0d rdy/vld/err=%b%b%b rdata=%h, required all 0",
                   d, i, rdy[d], vld[d], err[d], rd[d]);
        end
      end
    end
    rst = 3'b111; rv = 3'b000;
    @(negedge clk);
    tests++;
    if (rdy !== 3'b111) begin
      fails++;
      $display("FAIL reset_release_ready got %b, required 111", rdy);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] r; logic e; int lat;
    do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, r, e, lat);
    tests++;
    if (lat !== 3 || e !== 1'b0 || r !== 32'd0) begin
      fails++;
      $display("FAIL store_rsp lat=%0d err=%b rdata=%h, required lat=3 err=0 rdata=0", lat, e, r);
    end
    do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, r, e, lat);
    tests++;
    if (lat !== 3 || e !== 1'b0 || r !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL load_rsp lat=%0d err=%b rdata=%h, required lat=3 err=0 rdata=deadbeef", lat, e, r);
    end
  endtask

  task automatic test_range_error();
    logic [31:0] r; logic e; int lat;
    do_req(0, 1'b1, 1'b0, 32'h000, 32'h0BAD_F00D, r, e, lat);
    do_req(0, 1'b1, 1'b0, 32'h100, 32'h1234_5678, r, e, lat);
    tests++;
    if (lat !== 3 || e !== 1'b1 || r !== 32'd0) begin
      fails++;
      $display("FAIL range_err lat=%0d err=%b rdata=%h, required lat=3 err=1 rdata=0", lat, e, r);
    end
    do_req(0, 1'b0, 1'b0, 32'h000, 32'h0, r, e, lat);
    tests++;
    if (e !== 1'b0 || r !== 32'h0BAD_F00D) begin
      fails++;
      $display("FAIL range_nowrite err=%b rdata=%h, required err=0 rdata=0badf00d", e, r);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] r; logic e; int lat;
    do_req(0, 1'b0, 1'b0, 32'h12, 32'h0, r, e, lat);
    tests++;
    if (lat !== 3 || e !== 1'b1 || r !== 32'd0) begin
      fails++;
      $display("FAIL misalign_load lat=%0d err=%b rdata=%h, required lat=3 err=1 rdata=0", lat, e, r);
    end
    do_req(0, 1'b1, 1'b0, 32'h12, 32'h7777_7777, r, e, lat);
    tests++;
    if (e !== 1'b1) begin
      fails++;
      $display("FAIL misalign_store err=%b, required 1", e);
    end
    do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, r, e, lat);
    tests++;
    if (e !== 1'b0 || r !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL misalign_nowrite err=%b rdata=%h, required err=0 rdata=deadbeef", e, r);
    end
  endtask

`ifdef DMEM_BYTE_EN
  task automatic test_byte();
    logic [31:0] r; logic e; int lat;
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h1122_3344, r, e, lat);
    do_req(0, 1'b1, 1'b1, 32'h21, 32'hFFFF_FFAA, r, e, lat);
    tests++;
    if (e !== 1'b0) begin
      fails++;
      $display("FAIL strb_err err=%b, required 0", e);
    end
    do_req(0, 1'b0, 1'b0, 32'h20, 32'h0, r, e, lat);
    tests++;
    if (e !== 1'b0 || r !== 32'h1122_AA44) begin
      fails++;
      $display("FAIL strb_word err=%b rdata=%h, required err=0 rdata=1122aa44", e, r);
    end
    do_req(0, 1'b0, 1'b1, 32'h23, 32'h0, r, e, lat);
    tests++;
    if (e !== 1'b0 || r !== 32'h0000_0011) begin
      fails++;
      $display("FAIL ldrb err=%b rdata=%h, required err=0 rdata=00000011", e, r);
    end
  endtask
`endif

  task automatic test_reset_mid_wait();
    logic [31:0] r; logic e; int lat; logic saw;
    do_req(1, 1'b1, 1'b0, 32'h08, 32'h0102_0304, r, e, lat);
    tests++;
    if (lat !== 5 || e !== 1'b0) begin
      fails++;
      $display("FAIL w4_store lat=%0d err=%b, required lat=5 err=0", lat, e);
    end
    @(negedge clk);
    tests++;
    if (rdy[1] !== 1'b1) begin
      fails++;
      $display("FAIL w4_ready got %b, required 1", rdy[1]);
    end
    rv[1] = 1'b1; we[1] = 1'b1; ad[1] = 32'h08; wd[1] = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    rv[1] = 1'b0;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (vld[1]) saw = 1'b1;
      if (k == 2) rst[1] = 1'b1;
    end
    tests++;
    if (saw !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_rsp rsp_valid seen=%b, required 0", saw);
    end
    do_req(1, 1'b0, 1'b0, 32'h08, 32'h0, r, e, lat);
    tests++;
    if (lat !== 5 || e !== 1'b0 || r !== 32'h0102_0304) begin
      fails++;
      $display("FAIL abort_old_data lat=%0d err=%b rdata=%h, required lat=5 err=0 rdata=01020304",
               lat, e, r);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] r; logic e; int lat;
    do_req(2, 1'b1, 1'b0, 32'h3C, 32'hCAFE_F00D, r, e, lat);
    tests++;
    if (lat !== 1 || e !== 1'b0) begin
      fails++;
      $display("FAIL w0_store lat=%0d err=%b, required lat=1 err=0", lat, e);
    end
    do_req(2, 1'b0, 1'b0, 32'h3C, 32'h0, r, e, lat);
    tests++;
    if (lat !== 1 || r !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL w0_load lat=%0d rdata=%h, required lat=1 rdata=cafef00d", lat, r);
    end
    @(negedge clk);
    rv[2] = 1'b1; we[2] = 1'b0; ad[2] = 32'h3C;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      tests++;
      if (rdy[2] !== (i % 2 == 0) || vld[2] !== (i % 2 == 1) ||
          (i % 2 == 1 && rd[2] !== 32'hCAFE_F00D)) begin
        fails++;
        $display("FAIL w0_b2b cyc%0d rdy=%b vld=%b rdata=%h, required rdy=%0d vld=%0d",
                 i, rdy[2], vld[2], rd[2], (i % 2 == 0), (i % 2 == 1));
      end
    end
    rv[2] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_range_error();
    test_misaligned();
`ifdef DMEM_BYTE_EN
    test_byte();
`endif
    test_reset_mid_wait();
    test_zero_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
